// File: rtl/tamagotchi_pkg.sv
// Shared constants and types for the tamagotchi front end: action indices,
// input channel indices, default cycle counts and FSM state encodings.
package tamagotchi_pkg;

    localparam int unsigned ACT_FEED  = 0;
    localparam int unsigned ACT_LIGHT = 1;
    localparam int unsigned ACT_ECHO  = 2;
    localparam int unsigned ACT_HEAL  = 3;
    localparam int unsigned ACT_TEST  = 4;
    localparam int unsigned ACT_SEL   = 5;
    localparam int unsigned NUM_ACT   = 6;
    localparam int unsigned PEND_W    = 3;

    localparam int unsigned CH_FEED  = 0;
    localparam int unsigned CH_LIGHT = 1;
    localparam int unsigned CH_ECHO  = 2;
    localparam int unsigned CH_HEAL  = 3;
    localparam int unsigned CH_TEST  = 4;
    localparam int unsigned NUM_CH   = 5;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYC = CLK_HZ / 50;
    localparam int unsigned DEF_LONG_CYC     = CLK_HZ * 5;

    typedef enum logic {
        DEB_STABLE   = 1'b0,
        DEB_CHANGING = 1'b1
    } deb_state_e;

    typedef enum logic [1:0] {
        TST_IDLE      = 2'd0,
        TST_PRESSED   = 2'd1,
        TST_LONG_DONE = 2'd2
    } test_state_e;

    function automatic logic [PEND_W-1:0] popcount_act(input logic [NUM_ACT-1:0] v);
        logic [PEND_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_ACT; i++) begin
            c = c + PEND_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-channel debouncer: accepts a level change only after the synchronised
// input has differed from the debounced level for DEBOUNCE_CYC consecutive cycles.
module debounce_channel
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    deb_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_level, w_level_nxt;
    logic          r_rise, w_rise_nxt;
    logic          r_fall, w_fall_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DEB_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The first mismatching sample counts as 1, so the change lands on the Nth one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            DEB_STABLE: begin
                if (din != r_level) begin
                    w_state_nxt = DEB_CHANGING;
                    w_cnt_nxt   = CW'(1);
                end
            end
            DEB_CHANGING: begin
                if (din == r_level) begin
                    w_state_nxt = DEB_STABLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DEB_STABLE;
                    w_level_nxt = din;
                    w_rise_nxt  = din;
                    w_fall_nxt  = ~din;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = DEB_STABLE;
        endcase
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/action_input_conditioner.sv
// Turns raw buttons and sensor levels into single-cycle action pulses for the
// pet FSM: sync, debounce, short/long test-press split, one-pulse-per-cycle arbiter.
module action_input_conditioner
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC       = DEF_LONG_CYC,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_feed,
    input  logic              btn_heal,
    input  logic              btn_test,
    input  logic              light_dark,
    input  logic              echo_near,
    output logic              feeding,
    output logic              healing,
    output logic              light_out,
    output logic              echo_sig,
    output logic              change_state,
    output logic              test,
    output logic [PEND_W-1:0] pending
);

    localparam int unsigned HW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [NUM_CH-1:0] BTN_MASK = 5'b11001;

    logic [NUM_CH-1:0]  w_raw, w_pol, w_din, w_level, w_rise, w_fall;
    logic [NUM_CH-1:0]  r_sync1, r_sync2;
    test_state_e        r_tst_state, w_tst_state_nxt;
    logic [HW-1:0]      r_hold, w_hold_nxt;
    logic               w_req_test, w_req_sel;
    logic [NUM_ACT-1:0] w_req, w_grant, w_pend_nxt;
    logic [NUM_ACT-1:0] r_pend, r_out;
    logic [PEND_W-1:0]  r_pending;
    logic               w_unused;

    assign w_raw = {btn_test, btn_heal, echo_near, light_dark, btn_feed};
    assign w_pol = BTN_ACTIVE_LOW ? BTN_MASK : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_din = r_sync2 ^ w_pol;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
        debounce_channel #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .din  (w_din[g]),
            .level(w_level[g]),
            .rise (w_rise[g]),
            .fall (w_fall[g])
        );
    end

    // Levels and the falls of the four simple channels carry no action.
    assign w_unused = ^{w_level, w_fall[CH_HEAL:CH_FEED]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tst_state <= TST_IDLE;
            r_hold      <= '0;
        end else begin
            r_tst_state <= w_tst_state_nxt;
            r_hold      <= w_hold_nxt;
        end
    end

    // Test button: release before the hold threshold is a select, reaching it is a test.
    always_comb begin
        w_tst_state_nxt = r_tst_state;
        w_hold_nxt      = r_hold;
        w_req_test      = 1'b0;
        w_req_sel       = 1'b0;
        case (r_tst_state)
            TST_IDLE: begin
                if (w_rise[CH_TEST]) begin
                    w_tst_state_nxt = TST_PRESSED;
                    w_hold_nxt      = '0;
                end
            end
            TST_PRESSED: begin
                if (r_hold == HOLD_LAST) begin
                    w_req_test      = 1'b1;
                    w_tst_state_nxt = TST_LONG_DONE;
                end else if (w_fall[CH_TEST]) begin
                    w_req_sel       = 1'b1;
                    w_tst_state_nxt = TST_IDLE;
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            TST_LONG_DONE: begin
                if (w_fall[CH_TEST]) begin
                    w_tst_state_nxt = TST_IDLE;
                end
            end
            default: w_tst_state_nxt = TST_IDLE;
        endcase
    end

    always_comb begin
        w_req            = '0;
        w_req[ACT_FEED]  = w_rise[CH_FEED];
        w_req[ACT_LIGHT] = w_rise[CH_LIGHT];
        w_req[ACT_ECHO]  = w_rise[CH_ECHO];
        w_req[ACT_HEAL]  = w_rise[CH_HEAL];
        w_req[ACT_TEST]  = w_req_test;
        w_req[ACT_SEL]   = w_req_sel;
    end

    // Bit order is priority order, so the lowest set bit wins; a same-cycle request re-arms it.
    assign w_grant    = r_pend & (~r_pend + NUM_ACT'(1));
    assign w_pend_nxt = (r_pend & ~w_grant) | w_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_out     <= '0;
            r_pending <= '0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_out     <= w_grant;
            r_pending <= popcount_act(w_pend_nxt);
        end
    end

    assign feeding      = r_out[ACT_FEED];
    assign light_out    = r_out[ACT_LIGHT];
    assign echo_sig     = r_out[ACT_ECHO];
    assign healing      = r_out[ACT_HEAL];
    assign test         = r_out[ACT_TEST];
    assign change_state = r_out[ACT_SEL];
    assign pending      = r_pending;

endmodule

// File: tb/tb_action_input_conditioner.sv
// Directed bench for action_input_conditioner with DEBOUNCE_CYC=8, LONG_CYC=40.
module tb_action_input_conditioner;

    localparam int unsigned DEB = 8;
    localparam int unsigned LNG = 40;
    // Raw edge -> 2 sync -> DEB debounce -> pending set -> output register.
    localparam int LAT      = 2 + DEB + 1 + 1;
    // Debounced press at 2+DEB, PRESSED one cycle later, LNG-1 hold steps, pending, output.
    localparam int LAT_LONG = 2 + DEB + 1 + (LNG - 1) + 1 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_feed = 1'b1, btn_heal = 1'b1, btn_test = 1'b1;
    logic       light_dark = 1'b0, echo_near = 1'b0;
    logic       feeding, healing, light_out, echo_sig, change_state, test;
    logic [2:0] pending;

    action_input_conditioner #(
        .DEBOUNCE_CYC  (DEB),
        .LONG_CYC      (LNG),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_feed    (btn_feed),
        .btn_heal    (btn_heal),
        .btn_test    (btn_test),
        .light_dark  (light_dark),
        .echo_near   (echo_near),
        .feeding     (feeding),
        .healing     (healing),
        .light_out   (light_out),
        .echo_sig    (echo_sig),
        .change_state(change_state),
        .test        (test),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output index: 0 feed, 1 light, 2 echo, 3 heal, 4 test, 5 change_state.
    logic [5:0] outs;
    assign outs = {change_state, test, healing, echo_sig, light_out, feeding};

    int cyc = 0;
    int n_p[6];
    int first_p[6];

    always @(posedge clk) begin
        #2;
        cyc++;
        check("onehot", int'($countones(outs) > 1), 0);
        for (int i = 0; i < 6; i++) begin
            if (outs[i]) begin
                n_p[i]++;
                if (first_p[i] < 0) first_p[i] = cyc;
            end
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < 6; i++) begin
            n_p[i]     = 0;
            first_p[i] = -1;
        end
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < 6; i++) s += n_p[i];
        return s;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, int'(outs), 0);
        check({tag, "_pending"}, int'(pending), 0);
    endtask

    int t0;
    int lat;

    initial begin
        clear_counts();

        // Reset state
        wait_neg(3);
        check_all_zero("reset");
        rst = 1'b0;
        clear_counts();
        wait_neg(20);
        check("idle_no_pulse", total_pulses(), 0);

        // Bounce rejection: 5-cycle press, 3-cycle release, then held
        clear_counts();
        btn_feed = 1'b0;
        wait_neg(5);
        btn_feed = 1'b1;
        wait_neg(3);
        btn_feed = 1'b0;
        t0 = cyc;
        wait_neg(30);
        check("bounce_feed_cnt", n_p[0], 1);
        check("bounce_feed_lat", first_p[0] - t0, LAT);
        check("bounce_other", total_pulses(), 1);
        clear_counts();
        btn_feed = 1'b1;
        wait_neg(20);
        check("feed_release_none", total_pulses(), 0);

        // Short press -> change_state
        clear_counts();
        btn_test = 1'b0;
        wait_neg(20);
        btn_test = 1'b1;
        t0 = cyc;
        wait_neg(30);
        check("short_sel_cnt", n_p[5], 1);
        check("short_sel_lat", first_p[5] - t0, LAT);
        check("short_test_cnt", n_p[4], 0);

        // Long press -> test, nothing on release
        clear_counts();
        btn_test = 1'b0;
        t0 = cyc;
        wait_neg(60);
        btn_test = 1'b1;
        wait_neg(30);
        check("long_test_cnt", n_p[4], 1);
        check("long_test_lat", first_p[4] - t0, LAT_LONG);
        check("long_sel_cnt", n_p[5], 0);

        // Collision: feed, light, echo in the same cycle
        clear_counts();
        btn_feed   = 1'b0;
        light_dark = 1'b1;
        echo_near  = 1'b1;
        t0 = cyc;
        wait_neg(LAT - 1);
        check("coll_pend3", int'(pending), 3);
        check("coll_idle_outs", int'(outs), 0);
        wait_neg(1);
        check("coll_pend2", int'(pending), 2);
        check("coll_feed", int'(outs), 1);
        wait_neg(1);
        check("coll_pend1", int'(pending), 1);
        check("coll_light", int'(outs), 2);
        wait_neg(1);
        check("coll_pend0", int'(pending), 0);
        check("coll_echo", int'(outs), 4);
        wait_neg(10);
        check("coll_total", total_pulses(), 3);
        check("coll_feed_lat", first_p[0] - t0, LAT);
        check("coll_echo_lat", first_p[2] - t0, LAT + 2);
        clear_counts();
        btn_feed   = 1'b1;
        light_dark = 1'b0;
        echo_near  = 1'b0;
        wait_neg(20);
        check("coll_release_none", total_pulses(), 0);

        // Reset mid-debounce: echo pending, heal four samples into its debounce
        clear_counts();
        echo_near = 1'b1;
        wait_neg(5);
        btn_heal = 1'b0;
        wait_neg(6);
        check("pre_rst_pending", int'(pending), 1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        echo_near = 1'b0;
        wait_neg(3);
        rst = 1'b0;
        clear_counts();
        t0 = cyc;
        wait_neg(25);
        lat = first_p[3] - t0;
        check("rst_heal_cnt", n_p[3], 1);
        check("rst_heal_lat_ok", int'(lat >= 2 + int'(DEB) && lat <= LAT), 1);
        check("rst_echo_dropped", n_p[2], 0);
        check("rst_total", total_pulses(), 1);
        btn_heal = 1'b1;
        wait_neg(25);

        // Sensor fall gives nothing; next dark period fires again
        clear_counts();
        light_dark = 1'b1;
        t0 = cyc;
        wait_neg(20);
        check("dark1_cnt", n_p[1], 1);
        check("dark1_lat", first_p[1] - t0, LAT);
        clear_counts();
        light_dark = 1'b0;
        wait_neg(20);
        check("light_fall_none", total_pulses(), 0);
        clear_counts();
        light_dark = 1'b1;
        t0 = cyc;
        wait_neg(20);
        check("dark2_cnt", n_p[1], 1);
        check("dark2_lat", first_p[1] - t0, LAT);
        light_dark = 1'b0;
        wait_neg(20);
        check("final_pending", int'(pending), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
